// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared arbiter state/owner types and block geometry constants
package cpu_mem_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   localparam int BLOCK_BYTES = 16;
   localparam int WORD_BYTES  = 2;

endpackage

// File: rtl/fill_sequencer.sv
// rtl/fill_sequencer.sv - issue/receive counters, word address generation and last-word detect
module fill_sequencer
   import cpu_mem_pkg::*;
#(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int ADDR_W          = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               start_i,
   input  logic                               active_i,
   input  logic [ADDR_W-1:0]                  miss_addr_i,
   input  logic                               mem_valid_i,
   output logic                               issue_o,
   output logic [ADDR_W-1:0]                  addr_o,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] rcv_idx_o,
   output logic                               last_word_o
);

   localparam int                IDX_W    = $clog2(WORDS_PER_BLOCK);
   localparam int                OFF_W    = $clog2(WORDS_PER_BLOCK * WORD_BYTES);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
   localparam logic [IDX_W:0]    ISS_END  = (IDX_W + 1)'(WORDS_PER_BLOCK);
   localparam logic [IDX_W-1:0]  RCV_LAST = IDX_W'(WORDS_PER_BLOCK - 1);

   logic [ADDR_W-1:0] base_q, base_d;
   logic [IDX_W:0]    iss_q, iss_d;
   logic [IDX_W-1:0]  rcv_q, rcv_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         base_q <= '0;
         iss_q  <= '0;
         rcv_q  <= '0;
      end else begin
         base_q <= base_d;
         iss_q  <= iss_d;
         rcv_q  <= rcv_d;
      end
   end

   // Counters only move while the arbiter is in FILL, so stray mem_valid is harmless.
   always_comb begin
      base_d = base_q;
      iss_d  = iss_q;
      rcv_d  = rcv_q;
      if (start_i) begin
         base_d = miss_addr_i & ~OFF_MASK;
         iss_d  = '0;
         rcv_d  = '0;
      end else if (active_i) begin
         if (issue_o) begin
            iss_d = iss_q + 1'b1;
         end
         if (mem_valid_i) begin
            rcv_d = rcv_q + 1'b1;
         end
      end
   end

   assign issue_o     = active_i && (iss_q < ISS_END);
   assign addr_o      = base_q + ADDR_W'(iss_q) * ADDR_W'(WORD_BYTES);
   assign rcv_idx_o   = rcv_q;
   assign last_word_o = active_i && mem_valid_i && (rcv_q == RCV_LAST);

endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - shares main memory between I/D block fills and D write-through stores
// Define ARB_ROUND_ROBIN_EN to alternate between simultaneous I and D misses.
module cache_fill_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int WORDS_PER_BLOCK = BLOCK_BYTES / WORD_BYTES,
   parameter int MEM_LATENCY     = 4,
   parameter int ADDR_W          = 16
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               ic_miss_i,
   input  logic [ADDR_W-1:0]                  ic_miss_addr_i,
   input  logic                               dc_miss_i,
   input  logic [ADDR_W-1:0]                  dc_miss_addr_i,
   input  logic                               dc_wr_req_i,
   input  logic [ADDR_W-1:0]                  dc_wr_addr_i,
   input  logic [15:0]                        dc_wr_data_i,
   output logic                               dc_wr_ack_o,
   output logic                               mem_en_o,
   output logic                               mem_wr_o,
   output logic [ADDR_W-1:0]                  mem_addr_o,
   output logic [15:0]                        mem_wdata_o,
   input  logic [15:0]                        mem_rdata_i,
   input  logic                               mem_valid_i,
   output logic [15:0]                        fill_data_o,
   output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx_o,
   output logic                               ic_fill_we_o,
   output logic                               dc_fill_we_o,
   output logic                               ic_tag_we_o,
   output logic                               dc_tag_we_o,
   output logic                               ic_fill_done_o,
   output logic                               dc_fill_done_o,
   output logic                               busy_o
);

   if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 || MEM_LATENCY < 1)
   begin : g_bad_params
      $error("cache_fill_arbiter: WORDS_PER_BLOCK must be a power of two >= 2, MEM_LATENCY >= 1");
   end

   arb_state_t                         state_q, state_d;
   owner_t                             owner_q, owner_d, sel_owner;
   logic                               start_fill;
   logic                               seq_issue;
   logic                               seq_last;
   logic [ADDR_W-1:0]                  seq_addr;
   logic [ADDR_W-1:0]                  fill_addr;
   logic [$clog2(WORDS_PER_BLOCK)-1:0] seq_idx;

`ifdef ARB_ROUND_ROBIN_EN
   owner_t last_q, last_d;

   always_comb begin
      sel_owner = dc_miss_i ? OWN_D : OWN_I;
      if (dc_miss_i && ic_miss_i) begin
         sel_owner = (last_q == OWN_D) ? OWN_I : OWN_D;
      end
   end

   assign last_d = start_fill ? sel_owner : last_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= OWN_I;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign sel_owner = dc_miss_i ? OWN_D : OWN_I;
`endif

   assign start_fill = (state_q == IDLE) && !dc_wr_req_i && (dc_miss_i || ic_miss_i);
   assign owner_d    = start_fill ? sel_owner : owner_q;
   assign fill_addr  = (sel_owner == OWN_D) ? dc_miss_addr_i : ic_miss_addr_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= OWN_I;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dc_wr_req_i) begin
               state_d = WRITE;
            end else if (dc_miss_i || ic_miss_i) begin
               state_d = FILL;
            end
         end
         WRITE:   state_d = IDLE;
         FILL:    if (seq_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   fill_sequencer #(
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .ADDR_W          (ADDR_W)
   ) u_fill_sequencer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (start_fill),
      .active_i    (state_q == FILL),
      .miss_addr_i (fill_addr),
      .mem_valid_i (mem_valid_i),
      .issue_o     (seq_issue),
      .addr_o      (seq_addr),
      .rcv_idx_o   (seq_idx),
      .last_word_o (seq_last)
   );

   // Strobes are decoded from the registered state, so a reset clears them the next cycle.
   always_comb begin
      dc_wr_ack_o     = 1'b0;
      mem_en_o        = 1'b0;
      mem_wr_o        = 1'b0;
      mem_addr_o      = '0;
      mem_wdata_o     = '0;
      fill_word_idx_o = '0;
      ic_fill_we_o    = 1'b0;
      dc_fill_we_o    = 1'b0;
      ic_tag_we_o     = 1'b0;
      dc_tag_we_o     = 1'b0;
      ic_fill_done_o  = 1'b0;
      dc_fill_done_o  = 1'b0;
      case (state_q)
         WRITE: begin
            mem_en_o    = 1'b1;
            mem_wr_o    = 1'b1;
            mem_addr_o  = dc_wr_addr_i;
            mem_wdata_o = dc_wr_data_i;
            dc_wr_ack_o = 1'b1;
         end
         FILL: begin
            mem_en_o = seq_issue;
            if (seq_issue) begin
               mem_addr_o = seq_addr;
            end
            if (mem_valid_i) begin
               fill_word_idx_o = seq_idx;
               ic_fill_we_o    = (owner_q == OWN_I);
               dc_fill_we_o    = (owner_q == OWN_D);
               ic_tag_we_o     = seq_last && (owner_q == OWN_I);
               dc_tag_we_o     = seq_last && (owner_q == OWN_D);
            end
         end
         DONE: begin
            ic_fill_done_o = (owner_q == OWN_I);
            dc_fill_done_o = (owner_q == OWN_D);
         end
         default: ;
      endcase
   end

   assign busy_o      = (state_q != IDLE);
   assign fill_data_o = mem_rdata_i;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - directed vector bench for cache_fill_arbiter
module tb_cache_fill_arbiter;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_miss, dc_miss, dc_wr_req;
   logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
   logic        dc_wr_ack, mem_en, mem_wr, mem_valid, busy;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
   logic [2:0]  fill_word_idx;
   logic        ic_fill_we, dc_fill_we, ic_tag_we, dc_tag_we, ic_fill_done, dc_fill_done;
   logic        inj = 1'b0;

   logic [LAT-1:0] pv = '0;
   logic [15:0]    pd [LAT];
   logic [9:0]     ctl;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   cache_fill_arbiter dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .ic_miss_i       (ic_miss),
      .ic_miss_addr_i  (ic_miss_addr),
      .dc_miss_i       (dc_miss),
      .dc_miss_addr_i  (dc_miss_addr),
      .dc_wr_req_i     (dc_wr_req),
      .dc_wr_addr_i    (dc_wr_addr),
      .dc_wr_data_i    (dc_wr_data),
      .dc_wr_ack_o     (dc_wr_ack),
      .mem_en_o        (mem_en),
      .mem_wr_o        (mem_wr),
      .mem_addr_o      (mem_addr),
      .mem_wdata_o     (mem_wdata),
      .mem_rdata_i     (mem_rdata),
      .mem_valid_i     (mem_valid),
      .fill_data_o     (fill_data),
      .fill_word_idx_o (fill_word_idx),
      .ic_fill_we_o    (ic_fill_we),
      .dc_fill_we_o    (dc_fill_we),
      .ic_tag_we_o     (ic_tag_we),
      .dc_tag_we_o     (dc_tag_we),
      .ic_fill_done_o  (ic_fill_done),
      .dc_fill_done_o  (dc_fill_done),
      .busy_o          (busy)
   );

   // Pipelined read memory: data = address ^ 0xA5A5, returned LAT cycles after the read.
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], mem_en && !mem_wr};
      pd[0] <= mem_addr ^ 16'hA5A5;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end

   assign mem_valid = inj | pv[LAT-1];
   assign mem_rdata = inj ? 16'hC0DE : (pv[LAT-1] ? pd[LAT-1] : 16'h1357);
   assign ctl = {ic_fill_we, dc_fill_we, ic_tag_we, dc_tag_we, ic_fill_done, dc_fill_done,
                 dc_wr_ack, mem_en, mem_wr, busy};

   typedef struct {
      string       name;
      logic        ic;
      logic        dc;
      logic [15:0] ic_addr;
      logic [15:0] dc_addr;
      logic        exp_d;
      logic [15:0] base;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Called at the negedge of the IDLE cycle that samples the request.
   task automatic run_fill(input string tag, input logic own_d, input logic [15:0] base,
                           input int drop_idx);
      @(posedge clk);
      for (int c = 0; c <= 12; c++) begin
         logic       we, en;
         logic [9:0] exp;
         logic [15:0] a;
         @(negedge clk);
         en  = (c < 8);
         we  = (c >= 4) && (c <= 11);
         exp = {we && !own_d, we && own_d, (c == 11) && !own_d, (c == 11) && own_d,
                (c == 12) && !own_d, (c == 12) && own_d, 1'b0, en, 1'b0, 1'b1};
         chk($sformatf("%s c%0d strobes", tag, c), 32'(ctl), 32'(exp));
         if (en) chk($sformatf("%s c%0d mem_addr", tag, c), 32'(mem_addr), 32'(base + 16'(2 * c)));
         if (we) begin
            a = base + 16'(2 * (c - 4));
            chk($sformatf("%s c%0d idx", tag, c), 32'(fill_word_idx), 32'(c - 4));
            chk($sformatf("%s c%0d fill_data", tag, c), 32'(fill_data), 32'(a ^ 16'hA5A5));
         end
         if ((drop_idx >= 0 && c == drop_idx + 4) || c == 12) begin
            if (own_d) dc_miss = 1'b0;
            else ic_miss = 1'b0;
         end
      end
      @(negedge clk);
      chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{name: "v_ic1236", ic: 1'b1, dc: 1'b0, ic_addr: 16'h1236, dc_addr: 16'h0000, exp_d: 1'b0, base: 16'h1230};
      vecs[1] = '{name: "v_dc2a5f", ic: 1'b0, dc: 1'b1, ic_addr: 16'h0000, dc_addr: 16'h2A5F, exp_d: 1'b1, base: 16'h2A50};
      vecs[2] = '{name: "v_icfffe", ic: 1'b1, dc: 1'b0, ic_addr: 16'hFFFE, dc_addr: 16'h0000, exp_d: 1'b0, base: 16'hFFF0};
      vecs[3] = '{name: "v_dc0000", ic: 1'b0, dc: 1'b1, ic_addr: 16'h0000, dc_addr: 16'h0000, exp_d: 1'b1, base: 16'h0000};
      vecs[4] = '{name: "v_dc800f", ic: 1'b0, dc: 1'b1, ic_addr: 16'h0000, dc_addr: 16'h800F, exp_d: 1'b1, base: 16'h8000};

      rst = 1'b1; ic_miss = 1'b0; dc_miss = 1'b0; dc_wr_req = 1'b0;
      ic_miss_addr = '0; dc_miss_addr = '0; dc_wr_addr = '0; dc_wr_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset strobes", 32'(ctl), 32'd0);
      chk("reset mem_addr", 32'(mem_addr), 32'd0);
      chk("reset mem_wdata", 32'(mem_wdata), 32'd0);
      chk("reset idx", 32'(fill_word_idx), 32'd0);
      chk("reset fill_data", 32'(fill_data), 32'h1357);
      rst = 1'b0;

      // Store outranks both misses, then D fill, then I fill.
      dc_wr_req = 1'b1; dc_wr_addr = 16'h4000; dc_wr_data = 16'hBEEF;
      dc_miss = 1'b1; dc_miss_addr = 16'h6012;
      ic_miss = 1'b1; ic_miss_addr = 16'h7024;
      @(negedge clk);
      chk("write strobes", 32'(ctl), 32'(10'b0000001111));
      chk("write mem_addr", 32'(mem_addr), 32'h4000);
      chk("write mem_wdata", 32'(mem_wdata), 32'hBEEF);
      dc_wr_req = 1'b0;
      @(negedge clk);
      chk("write idle strobes", 32'(ctl), 32'd0);
      run_fill("prioD", 1'b1, 16'h6010, -1);
      run_fill("prioI", 1'b0, 16'h7020, -1);

      // Both misses pending twice in a row.
      dc_miss = 1'b1; dc_miss_addr = 16'h0102;
      ic_miss = 1'b1; ic_miss_addr = 16'h0204;
      run_fill("b2b_1st", 1'b1, 16'h0100, -1);
      dc_miss = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      run_fill("b2b_2nd", 1'b0, 16'h0200, -1);
      run_fill("b2b_rest", 1'b1, 16'h0100, -1);
`else
      run_fill("b2b_2nd", 1'b1, 16'h0100, -1);
      run_fill("b2b_rest", 1'b0, 16'h0200, -1);
`endif

      for (int v = 0; v < 5; v++) begin
         ic_miss = vecs[v].ic; ic_miss_addr = vecs[v].ic_addr;
         dc_miss = vecs[v].dc; dc_miss_addr = vecs[v].dc_addr;
         run_fill(vecs[v].name, vecs[v].exp_d, vecs[v].base, -1);
      end

      // Reset at the 5th issue cycle of a D fill; stale reads keep arriving.
      dc_miss = 1'b1; dc_miss_addr = 16'h0830;
      @(posedge clk);
      for (int c = 0; c <= 4; c++) @(negedge clk);
      chk("rst issue4 mem_addr", 32'(mem_addr), 32'h0838);
      rst = 1'b1; dc_miss = 1'b0;
      @(negedge clk);
      chk("rst next strobes", 32'(ctl), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("rst after c%0d strobes", c), 32'(ctl), 32'd0);
      end
      dc_miss = 1'b1; dc_miss_addr = 16'h0845;
      run_fill("post_rst", 1'b1, 16'h0840, -1);

      // I miss withdrawn once word 3 is written.
      ic_miss = 1'b1; ic_miss_addr = 16'h9ABC;
      run_fill("drop3", 1'b0, 16'h9AB0, 3);

      // mem_valid while IDLE must not write or advance counters.
      inj = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("idle valid c%0d strobes", c), 32'(ctl), 32'd0);
         chk($sformatf("idle valid c%0d idx", c), 32'(fill_word_idx), 32'd0);
         chk($sformatf("idle valid c%0d fill_data", c), 32'(fill_data), 32'hC0DE);
      end
      inj = 1'b0;
      ic_miss = 1'b1; ic_miss_addr = 16'h0010;
      run_fill("after_idle_valid", 1'b0, 16'h0010, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Shares the single-port, multi-cycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sequences each 16-byte block fill as 8 pipelined word reads and steers the returned words into the owning cache's data array.
- Issues tag-write and fill-done strobes to the owning cache.
- Sits between the fetch/memory-stage cache controllers and the main memory model; the pipeline stalls while the owning cache's miss is outstanding.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two.
- MEM_LATENCY, 4, cycles from mem_en sample to matching mem_valid; reads are pipelined, one per cycle.
- ADDR_W, 16, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ic_miss  in  1  I-cache miss pending; held until ic_fill_done.
- ic_miss_addr  in  ADDR_W  I-cache miss byte address.
- dc_miss  in  1  D-cache miss pending; held until dc_fill_done.
- dc_miss_addr  in  ADDR_W  D-cache miss byte address.
- dc_wr_req  in  1  write-through store request; held until dc_wr_ack.
- dc_wr_addr  in  ADDR_W  store byte address.
- dc_wr_data  in  16  store data.
- dc_wr_ack  out  1  one-cycle pulse; store accepted by memory.
- mem_en  out  1  memory access strobe.
- mem_wr  out  1  1 = write, 0 = read; valid with mem_en.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  mem_rdata valid.
- fill_data  out  16  word to write into the cache data array (mem_rdata passthrough).
- fill_word_idx  out  log2(WORDS_PER_BLOCK)  word slot being written.
- ic_fill_we  out  1  I-cache data-array write enable.
- dc_fill_we  out  1  D-cache data-array write enable.
- ic_tag_we  out  1  I-cache tag/valid write; asserted with the last ic_fill_we.
- dc_tag_we  out  1  D-cache tag/valid write; asserted with the last dc_fill_we.
- ic_fill_done  out  1  one-cycle pulse, cycle after ic_tag_we.
- dc_fill_done  out  1  one-cycle pulse, cycle after dc_tag_we.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset:
  - State IDLE, counters 0, owner cleared.
  - Every output 0, except fill_data, which equals mem_rdata.
- States: IDLE, WRITE, FILL, DONE.
- Arbitration in IDLE, fixed priority: dc_wr_req > dc_miss > ic_miss.
  - Decision is registered; the owner is latched on the IDLE→FILL transition.
  - No request: stay IDLE.
- Request-to-access latency is 1 cycle: the selected access appears on the memory interface in the cycle after IDLE samples the request.
- WRITE (1 cycle):
  - mem_en = 1, mem_wr = 1, mem_addr = dc_wr_addr, mem_wdata = dc_wr_data, dc_wr_ack = 1.
  - Next state IDLE.
- FILL:
  - Block base = miss_addr with bits [log2(WORDS_PER_BLOCK)+0:0] cleared, i.e. [3:0] = 0 at default.
  - Issue counter iss, 0..WORDS_PER_BLOCK. While iss < WORDS_PER_BLOCK: mem_en = 1, mem_wr = 0, mem_addr = base + 2*iss, iss++.
  - Receive counter rcv, 0..WORDS_PER_BLOCK-1. On each mem_valid: fill_word_idx = rcv, owner's fill_we = 1, rcv++.
  - On the mem_valid where rcv = WORDS_PER_BLOCK-1: owner's tag_we = 1, next state DONE.
  - Nominal fill at defaults: 8 issue cycles, last data at cycle 8+MEM_LATENCY-1 after FILL entry, DONE one cycle later.
- DONE (1 cycle): owner's fill_done = 1, next state IDLE.
- Word order is strictly ascending (base first), independent of the miss offset.
- Requests during FILL/WRITE/DONE are not served; they wait for IDLE. A request arriving in DONE is arbitrated in the following IDLE cycle.
- Miss deasserted mid-fill: the fill still completes; the block is written and tagged.
- mem_valid outside FILL is ignored: no fill_we, no counter change. This covers stale reads in flight across a reset.
- Reset mid-operation: next cycle is IDLE with all strobes 0, and the partial fill is discarded. No tag_we is issued, so the cache line stays invalid.
- Address arithmetic is ADDR_W bits; base + 2*iss never wraps because base is block-aligned.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds a 1-bit last_fill_owner register, reset to I.
  - When dc_miss and ic_miss are both pending in IDLE and no store is pending, the miss not served last wins. The register updates on FILL entry.
  - dc_wr_req keeps top priority.
- Undefined: fixed priority D over I; no extra register.

Decomposition:
- Shared package cpu_mem_pkg:
  - arb_state_t enum {IDLE, WRITE, FILL, DONE}.
  - owner_t enum {OWN_I, OWN_D}.
  - Constants BLOCK_BYTES = 16, WORD_BYTES = 2.
- One natural sub-module: fill_sequencer, holding the iss/rcv counters, address generation and last-word detect. The arbiter FSM instantiates it per fill via a start pulse and receives a last_word signal.

Test Plan:
- ic_miss = 1, ic_miss_addr = 0x1236 → mem reads 0x1230, 0x1232, …, 0x123E on consecutive cycles. ic_fill_we with idx 0..7 as mem_valid returns. ic_tag_we with idx 7, then ic_fill_done one cycle later. dc_* strobes stay 0.
- dc_wr_req = 1, addr 0x4000, data 0xBEEF, with dc_miss and ic_miss also set → first access is a write: mem_wr = 1, mem_addr 0x4000, mem_wdata 0xBEEF, dc_wr_ack pulse. D fill follows, then I fill.
- dc_miss and ic_miss asserted together twice back-to-back → without the macro, D then D; with ARB_ROUND_ROBIN_EN, D then I.
- rst pulsed at the 5th issue cycle of a D fill, with mem_valid continuing 4 more cycles → busy = 0, no dc_fill_we, no dc_tag_we, no dc_fill_done after reset.
- ic_miss dropped at rcv = 3 → all 8 ic_fill_we still occur, plus ic_tag_we and ic_fill_done.
- mem_valid pulsed while IDLE → no fill_we of either cache, counters unchanged (next fill still starts at idx 0).
